// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed Booth multiply / restoring divide, one iteration per clock
//   clock, ctrl_reset (sync, active-high); ctrl_MULT/ctrl_DIV start pulses (MULT wins)
//   data_operandA/B operands latched at capture; data_result/data_exception held until next completion
//   data_resultRDY one-cycle strobe in the cycle after the final load edge
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] acc, op, sum, rsh;
  logic [WIDTH-1:0] lo, mag_a, mag_b, quo;
  logic qb, neg, divz, ovf, last, ge, m_ovf, start;
  assign start = ctrl_MULT | ctrl_DIV;
  assign last = cnt == CW'(WIDTH);
  assign data_resultRDY = state == DONE;
  always_comb begin
    next = start ? (ctrl_MULT ? MULT : DIV) : state == DONE ? IDLE : (state != IDLE && last) ? DONE : state;
  end
  // acc is one bit wider than the operand so adding/subtracting the most negative multiplicand cannot wrap
  always_comb begin
    mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    sum = {lo[0], qb} == 2'b01 ? acc + op : {lo[0], qb} == 2'b10 ? acc - op : acc;
    rsh = {acc[WIDTH-1:0], lo[WIDTH-1]};
    ge = rsh >= op;
    quo = neg ? -lo : lo;
    m_ovf = ~(&{acc[WIDTH-1:0], lo[WIDTH-1]} | ~|{acc[WIDTH-1:0], lo[WIDTH-1]});
  end
  // mult: {acc, lo, qb} is the Booth register; div: acc is the partial remainder, lo shifts dividend out and quotient in
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      op <= '0;
      lo <= '0;
      qb <= 1'b0;
      neg <= 1'b0;
      divz <= 1'b0;
      ovf <= 1'b0;
      data_result <= '0;
      data_exception <= 1'b0;
    end else begin
      state <= next;
      if (start) begin
        cnt <= '0;
        acc <= '0;
        qb <= 1'b0;
        op <= ctrl_MULT ? {data_operandA[WIDTH-1], data_operandA} : {1'b0, mag_b};
        lo <= ctrl_MULT ? data_operandB : mag_a;
        neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        divz <= data_operandB == '0;
        ovf <= data_operandA == {1'b1, {(WIDTH-1){1'b0}}} && &data_operandB;
      end else if (state == MULT && !last) begin
        {acc, lo, qb} <= {sum[WIDTH], sum, lo};
        cnt <= cnt + 1'b1;
      end else if (state == DIV && !last) begin
        acc <= ge ? rsh - op : rsh;
        lo <= {lo[WIDTH-2:0], ge};
        cnt <= cnt + 1'b1;
      end else if (state == MULT) begin
        data_result <= lo;
        data_exception <= m_ovf;
      end else if (state == DIV) begin
        data_result <= divz ? '0 : quo;
        data_exception <= divz | ovf;
      end
    end
  end
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed bench with an arithmetic reference model and per-cycle output comparison
module tb_multdiv_unit;
  logic clock = 1'b0;
  logic ctrl_reset, ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic data_exception, data_resultRDY;
  int checks = 0, errors = 0;
  logic lit_en = 1'b0, lit_exc = 1'b0;
  logic [31:0] lit_res = '0;
  logic pend = 1'b0, mrdy = 1'b0, mexc = 1'b0, rst_seen = 1'b0;
  logic [31:0] mres = '0;
  logic [32:0] exp_v = '0;
  int cnt = 0;
  logic plit_en = 1'b0, plit_exc = 1'b0, hl_en = 1'b0, hl_exc = 1'b0;
  logic [31:0] plit_res = '0, hl_res = '0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception), .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  // {exception, result} from plain signed arithmetic
  function automatic logic [32:0] model(input logic is_mult, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int lo32, sa, sb, q;
    if (is_mult) begin
      p = longint'($signed(a)) * longint'($signed(b));
      lo32 = int'(p[31:0]);
      return {p != longint'(lo32), p[31:0]};
    end
    if (b == 32'h0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    sa = a;
    sb = b;
    q = sa / sb;
    return {1'b0, 32'(q)};
  endfunction

  // completion is expected exactly 33 edges after capture; start or reset discards the pending result
  always @(posedge clock) begin
    if (ctrl_reset) begin
      pend <= 1'b0;
      mrdy <= 1'b0;
      mres <= '0;
      mexc <= 1'b0;
      hl_en <= 1'b0;
      rst_seen <= 1'b1;
    end else begin
      rst_seen <= 1'b0;
      mrdy <= 1'b0;
      if (ctrl_MULT || ctrl_DIV) begin
        pend <= 1'b1;
        cnt <= 33;
        exp_v <= model(ctrl_MULT, data_operandA, data_operandB);
        plit_en <= lit_en;
        plit_res <= lit_res;
        plit_exc <= lit_exc;
      end else if (pend) begin
        if (cnt == 1) begin
          pend <= 1'b0;
          mrdy <= 1'b1;
          mres <= exp_v[31:0];
          mexc <= exp_v[32];
          hl_en <= plit_en;
          hl_res <= plit_res;
          hl_exc <= plit_exc;
        end else cnt <= cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    chk("rdy", 32'(data_resultRDY), 32'(mrdy));
    chk("result", data_result, mres);
    chk("exception", 32'(data_exception), 32'(mexc));
    if (mrdy && hl_en) begin
      chk("lit_result", data_result, hl_res);
      chk("lit_exception", 32'(data_exception), 32'(hl_exc));
    end
    if (rst_seen) begin
      chk("reset_result", data_result, 32'h0);
      chk("reset_rdy", 32'(data_resultRDY), 32'h0);
    end
  end

  task automatic run(input logic m, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lr, input logic le, input int gap);
    lit_en = 1'b1;
    lit_res = lr;
    lit_exc = le;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = m;
    ctrl_DIV = !m;
    @(posedge clock);
    #2;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom();
    data_operandB = $urandom();
    repeat (gap) @(posedge clock);
    #2;
  endtask

  initial begin
    ctrl_reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #2;
    ctrl_reset = 1'b0;
    run(1, 32'd7, -32'sd3, 32'hFFFF_FFEB, 0, 34);
    run(1, -32'sd7, -32'sd3, 32'd21, 0, 34);
    run(1, 32'h0001_0000, 32'h0001_0000, 32'h0, 1, 34);
    run(1, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 0, 34);
    run(0, -32'sd7, 32'd2, 32'hFFFF_FFFD, 0, 34);
    run(0, 32'd100, 32'd7, 32'd14, 0, 34);
    run(0, 32'd0, 32'd5, 32'd0, 0, 34);
    run(0, 32'd5, 32'd0, 32'd0, 1, 34);
    run(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 34);
    // next start lands on the DONE cycle
    run(1, 32'd123, -32'sd45, 32'hFFFF_EA61, 0, 33);
    run(0, -32'sd100, 32'd7, 32'hFFFF_FFF2, 0, 34);
    run(1, 32'h8000_0000, 32'h8000_0000, 32'h0, 1, 34);
    // abort: DIV captured at E10 of a MULT
    run(1, 32'd3, 32'd4, 32'd12, 0, 9);
    run(0, 32'd100, 32'd7, 32'd14, 0, 34);
    // reset sampled at E15 of a MULT
    run(1, 32'd9, 32'd9, 32'd81, 0, 14);
    ctrl_reset = 1'b1;
    @(posedge clock);
    #2;
    ctrl_reset = 1'b0;
    repeat (40) @(posedge clock);
    #2;
    run(1, 32'd6, 32'd7, 32'd42, 0, 34);
    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
